rgb_pwm_led: RTL and testbench

Parametrised multi-channel PWM LED driver; successor to the free-running-counter LED blink logic in the board top level. Each channel independently runs OFF, static PWM, blink or breathe mode at a programmable duty. Outputs are active-low and drive the RGB LED pins directly. Configuration arrives over a valid/ready write port and takes effect only at PWM period boundaries, so outputs never glitch.

---
 rtl/rgb_pwm_pkg.sv | 13 +
 rtl/rgb_pwm_channel.sv | 72 +++++++
 rtl/rgb_pwm_led.sv | 115 +++++++++++
 tb/tb_rgb_pwm_led.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared types for the RGB PWM LED driver: per-channel mode encoding.
package rgb_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_PWM     = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One LED channel: mode/duty registers, breathe ramp, level select and PWM compare.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk48,
    input  logic                rst_n,
    input  logic                boundary,
    input  logic                load,
    input  mode_e               load_mode,
    input  logic [PWM_BITS-1:0] load_duty,
    input  logic                blink_phase,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                on
);

    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    mode_e               mode;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] lvl;
    logic                dir_up;
    logic [PWM_BITS-1:0] level;

    // A fresh write restarts the breathe ramp and suppresses this boundary's step.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_OFF;
            duty   <= '0;
            lvl    <= '0;
            dir_up <= 1'b1;
        end else if (boundary) begin
            if (load) begin
                mode   <= load_mode;
                duty   <= load_duty;
                lvl    <= '0;
                dir_up <= 1'b1;
            end else if (mode == MODE_BREATHE) begin
                if (dir_up) begin
                    if (lvl < duty) begin
                        lvl <= lvl + ONE;
                    end else begin
                        dir_up <= 1'b0;
                        if (lvl != '0) lvl <= lvl - ONE;
                    end
                end else begin
                    if (lvl != '0) begin
                        lvl <= lvl - ONE;
                    end else begin
                        dir_up <= 1'b1;
                        if (duty != '0) lvl <= lvl + ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        // NOTE: default assigned first so the mux can never infer a latch.
        level = '0;
        unique case (mode)
            MODE_OFF:     level = '0;
            MODE_PWM:     level = duty;
            MODE_BLINK:   level = blink_phase ? duty : '0;
            MODE_BREATHE: level = lvl;
        endcase
    end

    assign on = (pwm_cnt < level);

endmodule

// File: rtl/rgb_pwm_led.sv
// Multi-channel active-low PWM LED driver; config writes are staged and applied
// only at PWM period boundaries so the outputs never glitch.
module rgb_pwm_led
    import rgb_pwm_pkg::*;
#(
    parameter int  CHANNELS      = 3,
    parameter int  PWM_BITS      = 8,
    parameter int  PRESCALE      = 4,
    parameter int  BLINK_PERIODS = 64,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk48,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [CHANNELS-1:0] led_n,
    output logic                period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [BL_W-1:0]     BL_MAX  = BL_W'(BLINK_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BL_W-1:0]     blink_cnt;
    logic                blink_phase;
    logic                tick;
    logic                boundary;
    logic                accept;
    logic                apply;
    logic                pending;
    logic [CH_W-1:0]     pend_ch;
    mode_e               pend_mode;
    logic [PWM_BITS-1:0] pend_duty;
    logic [CHANNELS-1:0] on;

    assign tick      = (presc == PS_MAX);
    assign boundary  = tick && (pwm_cnt == '1);
    assign cfg_ready = ~pending;
    assign accept    = cfg_valid && cfg_ready;
    assign apply     = boundary && pending;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            presc <= tick ? '0 : presc + PS_W'(1);
            if (tick) pwm_cnt <= pwm_cnt + PWM_ONE;
            if (boundary) begin
                if (blink_cnt == BL_MAX) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BL_W'(1);
                end
            end
        end
    end

    // Single staging slot; accept and apply are mutually exclusive since
    // accept needs the slot empty and apply needs it full.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            pend_ch   <= '0;
            pend_mode <= MODE_OFF;
            pend_duty <= '0;
        end else if (accept) begin
            pending   <= 1'b1;
            pend_ch   <= cfg_ch;
            pend_mode <= mode_e'(cfg_mode);
            pend_duty <= cfg_duty;
        end else if (apply) begin
            pending <= 1'b0;
        end
    end

    // Writes addressed beyond the last channel match no instance and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk48      (clk48),
            .rst_n      (rst_n),
            .boundary   (boundary),
            .load       (apply && (pend_ch == CH_W'(i))),
            .load_mode  (pend_mode),
            .load_duty  (pend_duty),
            .blink_phase(blink_phase),
            .pwm_cnt    (pwm_cnt),
            .on         (on[i])
        );
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            led_n        <= '1;
            period_start <= 1'b0;
        end else begin
            led_n        <= ~on;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_led.sv
// Directed bench for rgb_pwm_led with PRESCALE=1, PWM_BITS=4, BLINK_PERIODS=2.
module tb_rgb_pwm_led;
    import rgb_pwm_pkg::*;

    localparam int CH   = 3;
    localparam int PB   = 4;
    localparam int NPOS = 16;
    localparam int MAXW = 64;

    logic          clk48 = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [PB-1:0] cfg_duty = '0;
    logic [CH-1:0] led_n;
    logic          period_start;

    int vectors = 0;
    int miscompares = 0;

    // Window k = the 16 led_n samples following the k-th period_start since reset.
    int            nb = 0;
    int            pos = 0;
    logic [CH-1:0] hist [0:MAXW-1][0:NPOS-1];

    always #5 clk48 = ~clk48;

    rgb_pwm_led #(
        .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(1), .BLINK_PERIODS(2)
    ) dut (
        .clk48(clk48), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
        .led_n(led_n), .period_start(period_start)
    );

    always @(negedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            nb  <= 0;
            pos <= 0;
        end else begin
            if (nb >= 1 && nb < MAXW && pos < NPOS) hist[nb][pos] <= led_n;
            if (period_start) begin
                nb  <= nb + 1;
                pos <= 0;
            end else if (pos < NPOS) begin
                pos <= pos + 1;
            end
        end
    end

    function automatic logic [NPOS-1:0] low_mask(input int k, input int ch);
        logic [NPOS-1:0] m;
        m = 'x;
        if (k >= 1 && k < MAXW)
            for (int p = 0; p < NPOS; p++) m[p] = ~hist[k][p][ch];
        return m;
    endfunction

    task automatic step();
        @(negedge clk48);
        #1;
    endtask

    task automatic wait_ps(output int k);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (period_start !== 1'b1 && n < 40);
        if (period_start !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL wait_period_start: period_start=%b after %0d cycles, required 1", period_start, n);
        end
        k = nb;
    endtask

    task automatic wait_windows(input int k);
        int n;
        n = 0;
        while (nb <= k && n < 40 * NPOS) begin
            step();
            n++;
        end
        if (nb <= k) begin
            vectors++; miscompares++;
            $display("FAIL wait_windows: reached window %0d, required %0d", nb, k + 1);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input mode_e mode, input logic [PB-1:0] duty);
        int n;
        cfg_ch = ch; cfg_mode = mode; cfg_duty = duty; cfg_valid = 1'b1;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (cfg_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL cfg_write_timeout: cfg_ready=%b, required 1", cfg_ready);
        end else begin
            @(posedge clk48);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        int   n;
        logic any_low;
        rst_n = 1'b0; cfg_valid = 1'b0;
        repeat (3) step();
        vectors++;
        if (led_n !== 3'b111) begin miscompares++; $display("FAIL reset_led_n: got %b, required 111", led_n); end
        vectors++;
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready); end
        vectors++;
        if (period_start !== 1'b0) begin miscompares++; $display("FAIL reset_period_start: got %b, required 0", period_start); end
        rst_n = 1'b1;
        n = 0; any_low = 1'b0;
        do begin
            step();
            n++;
            any_low = any_low | ~&led_n;
        end while (period_start !== 1'b1 && n < 40);
        vectors++;
        if (n != 16) begin miscompares++; $display("FAIL first_period_start: after %0d cycles, required 16", n); end
        vectors++;
        if (any_low !== 1'b0) begin miscompares++; $display("FAIL idle_led_n: some led low=%b, required 0", any_low); end
        n = 0;
        do begin
            step();
            n++;
        end while (period_start !== 1'b1 && n < 40);
        vectors++;
        if (n != 16) begin miscompares++; $display("FAIL period_interval: %0d cycles, required 16", n); end
    endtask

    task automatic test_pwm();
        int              k;
        logic [NPOS-1:0] exp0;
        wait_ps(k);
        cfg_write(2'd0, MODE_PWM, 4'd4);
        wait_windows(k + 2);
        for (int j = 0; j <= 2; j++) begin
            exp0 = (j == 0) ? 16'h0000 : 16'h000F;
            vectors++;
            if (low_mask(k + j, 0) !== exp0) begin
                miscompares++;
                $display("FAIL pwm_ch0 win+%0d: got %h, required %h", j, low_mask(k + j, 0), exp0);
            end
            for (int c = 1; c < CH; c++) begin
                vectors++;
                if (low_mask(k + j, c) !== 16'h0000) begin
                    miscompares++;
                    $display("FAIL pwm_ch%0d win+%0d: got %h, required 0000", c, j, low_mask(k + j, c));
                end
            end
        end
    endtask

    task automatic test_handshake();
        int              k;
        int              n;
        logic [NPOS-1:0] exp1 [4];
        exp1 = '{16'h00FF, 16'h0003, 16'h0003, 16'h0003};
        wait_ps(k);
        repeat (5) step();
        cfg_ch = 2'd1; cfg_mode = MODE_PWM; cfg_duty = 4'd8; cfg_valid = 1'b1;
        vectors++;
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL hs_ready_idle: got %b, required 1", cfg_ready); end
        @(posedge clk48);
        step();
        cfg_duty = 4'd2;
        vectors++;
        if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL hs_ready_busy: got %b, required 0", cfg_ready); end
        n = 0;
        while (cfg_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (n != 10) begin miscompares++; $display("FAIL hs_ready_low_len: %0d cycles, required 10", n); end
        vectors++;
        if (period_start !== 1'b1) begin miscompares++; $display("FAIL hs_ready_at_boundary: period_start=%b, required 1", period_start); end
        vectors++;
        if (nb != k + 1) begin miscompares++; $display("FAIL hs_apply_period: window %0d, required %0d", nb, k + 1); end
        @(posedge clk48);
        step();
        cfg_valid = 1'b0;
        cfg_write(2'd3, MODE_PWM, 4'd15);
        wait_windows(k + 4);
        for (int j = 1; j <= 4; j++) begin
            vectors++;
            if (low_mask(k + j, 0) !== 16'h000F) begin
                miscompares++;
                $display("FAIL hs_ch0 win+%0d: got %h, required 000F", j, low_mask(k + j, 0));
            end
            vectors++;
            if (low_mask(k + j, 1) !== exp1[j-1]) begin
                miscompares++;
                $display("FAIL hs_ch1 win+%0d: got %h, required %h", j, low_mask(k + j, 1), exp1[j-1]);
            end
            vectors++;
            if (low_mask(k + j, 2) !== 16'h0000) begin
                miscompares++;
                $display("FAIL hs_ch2 win+%0d: got %h, required 0000", j, low_mask(k + j, 2));
            end
        end
    endtask

    task automatic test_breathe();
        int              k;
        int              lows [9];
        logic [NPOS-1:0] exp2;
        lows = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
        wait_ps(k);
        cfg_write(2'd2, MODE_BREATHE, 4'd3);
        wait_windows(k + 9);
        for (int j = 1; j <= 9; j++) begin
            exp2 = NPOS'((1 << lows[j-1]) - 1);
            vectors++;
            if (low_mask(k + j, 2) !== exp2) begin
                miscompares++;
                $display("FAIL breathe_ch2 win+%0d: got %h, required %h", j, low_mask(k + j, 2), exp2);
            end
        end
    endtask

    task automatic test_blink();
        int              k;
        logic [NPOS-1:0] exp0;
        wait_ps(k);
        cfg_write(2'd0, MODE_BLINK, 4'd15);
        wait_windows(k + 4);
        for (int j = 1; j <= 4; j++) begin
            exp0 = (((k + j) / 2) % 2 == 1) ? 16'h7FFF : 16'h0000;
            vectors++;
            if (low_mask(k + j, 0) !== exp0) begin
                miscompares++;
                $display("FAIL blink_ch0 win%0d: got %h, required %h", k + j, low_mask(k + j, 0), exp0);
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        wait_ps(k);
        cfg_write(2'd0, MODE_PWM, 4'd10);
        vectors++;
        if (led_n[1] !== 1'b0) begin miscompares++; $display("FAIL ar_pre_led1: got %b, required 0", led_n[1]); end
        vectors++;
        if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL ar_pre_pending: cfg_ready=%b, required 0", cfg_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (led_n !== 3'b111) begin miscompares++; $display("FAIL ar_led_n: got %b, required 111", led_n); end
        vectors++;
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL ar_cfg_ready: got %b, required 1", cfg_ready); end
        repeat (2) step();
        rst_n = 1'b1;
        wait_windows(3);
        for (int j = 1; j <= 3; j++) begin
            for (int c = 0; c < CH; c++) begin
                vectors++;
                if (low_mask(j, c) !== 16'h0000) begin
                    miscompares++;
                    $display("FAIL ar_post_ch%0d win%0d: got %h, required 0000", c, j, low_mask(j, c));
                end
            end
        end
        vectors++;
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL ar_post_ready: got %b, required 1", cfg_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pwm();
        test_handshake();
        test_breathe();
        test_blink();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
